// File: rtl/a5_1_decipher.sv
// A5/1 stream decipher: key/frame load, 100-cycle mix, then 114 bits
// of ciphertext XOR keystream with one-cycle latency.
module a5_1_decipher (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  output logic        ready,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        data_ready,
  output logic        out_valid,
  output logic        out_bit,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_KEY, LOAD_FRAME, MIX, RUN
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] key_q, key_d;
  logic [21:0] frame_q, frame_d;
  logic [18:0] r1_q, r1_d;
  logic [21:0] r2_q, r2_d;
  logic [22:0] r3_q, r3_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic        out_bit_q, out_bit_d;
  logic        done_q, done_d;

  logic        maj;
  logic [18:0] m1;
  logic [21:0] m2;
  logic [22:0] m3;

  function automatic logic [18:0] step1(
    input logic [18:0] r, input logic inj);
    return {r[17:0], r[13] ^ r[16] ^ r[17] ^ r[18] ^ inj};
  endfunction

  function automatic logic [21:0] step2(
    input logic [21:0] r, input logic inj);
    return {r[20:0], r[20] ^ r[21] ^ inj};
  endfunction

  function automatic logic [22:0] step3(
    input logic [22:0] r, input logic inj);
    return {r[21:0], r[7] ^ r[20] ^ r[21] ^ r[22] ^ inj};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      key_q       <= '0;
      frame_q     <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      frame_q     <= frame_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = LOAD_KEY;
      LOAD_KEY:   if (cnt_q == 7'd63) state_d = LOAD_FRAME;
      LOAD_FRAME: if (cnt_q == 7'd21) state_d = MIX;
      MIX:        if (cnt_q == 7'd99) state_d = RUN;
      RUN:
        if (in_valid && cnt_q == 7'd113) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Majority-clocked candidates, shared by MIX and RUN
  always_comb begin
    maj = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) |
          (r2_q[10] & r3_q[10]);
    m1  = (r1_q[8] == maj) ? step1(r1_q, 1'b0) : r1_q;
    m2  = (r2_q[10] == maj) ? step2(r2_q, 1'b0) : r2_q;
    m3  = (r3_q[10] == maj) ? step3(r3_q, 1'b0) : r3_q;
  end

  always_comb begin
    key_d       = key_q;
    frame_d     = frame_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_bit_d   = out_bit_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = key;
          frame_d = frame;
          r1_d    = '0;
          r2_d    = '0;
          r3_d    = '0;
          cnt_d   = '0;
        end
      end
      LOAD_KEY: begin
        r1_d  = step1(r1_q, key_q[cnt_q[5:0]]);
        r2_d  = step2(r2_q, key_q[cnt_q[5:0]]);
        r3_d  = step3(r3_q, key_q[cnt_q[5:0]]);
        cnt_d = (cnt_q == 7'd63) ? 7'd0 : cnt_q + 7'd1;
      end
      LOAD_FRAME: begin
        r1_d  = step1(r1_q, frame_q[cnt_q[4:0]]);
        r2_d  = step2(r2_q, frame_q[cnt_q[4:0]]);
        r3_d  = step3(r3_q, frame_q[cnt_q[4:0]]);
        cnt_d = (cnt_q == 7'd21) ? 7'd0 : cnt_q + 7'd1;
      end
      MIX: begin
        r1_d  = m1;
        r2_d  = m2;
        r3_d  = m3;
        cnt_d = (cnt_q == 7'd99) ? 7'd0 : cnt_q + 7'd1;
      end
      RUN: begin
        if (in_valid) begin
          r1_d        = m1;
          r2_d        = m2;
          r3_d        = m3;
          out_valid_d = 1'b1;
          out_bit_d   = in_bit ^ m1[18] ^ m2[21] ^ m3[22];
          if (cnt_q == 7'd113) begin
            cnt_d  = 7'd0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready      = (state_q == IDLE);
    data_ready = (state_q == RUN);
    out_valid  = out_valid_q;
    out_bit    = out_bit_q;
    done       = done_q;
  end

endmodule
